data_ram_responder: RTL and testbench

Responder end of the core's data-RAM request interface: it receives the chip-enable/read/write/address/write-data requests that the execution unit issues for loads, stores, atomics and compressed loads/stores, services them from a 64 x 32-bit on-chip word array, and returns read data with a completion handshake. It sits between the execution unit's muxed RAM request port and the data storage, and provides the busy/ack signals the core uses to stall.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_array.sv | 24 ++
 rtl/data_ram_responder.sv | 104 ++++++++++
 tb/tb_data_ram_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the data-RAM request interface: geometry defaults,
// responder FSM encoding and the byte-address to word-index slice.
package ram_pkg;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 7;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_RESP  = 2'd2,
    S_WRITE = 2'd3
  } ram_state_e;
endpackage

// File: rtl/ram_array.sv
// Single-port DEPTH x DATA_W word store: synchronous read, synchronous write,
// contents deliberately not reset so they survive a core reset.
module ram_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_ram_responder.sv
// Responder for the execution unit's data-RAM port: accepts one edge-armed
// request per CE assertion, services it from ram_array and handshakes back.
module data_ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH  = ram_pkg::DEPTH,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRAM_CE,
  input  logic              iRAM_RD,
  input  logic              iRAM_WR,
  input  logic [ADDR_W-1:0] iRAM_ADDR,
  input  logic [DATA_W-1:0] iRAM_DATA,
  output logic [DATA_W-1:0] oRAM_DATA,
  output logic              oRAM_BUSY,
  output logic              oRAM_ACK,
  output logic              oRAM_ERR
);
  localparam int AW = $clog2(DEPTH);

  ram_state_e        r_state;
  logic              r_armed;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data;
  logic              r_ack;
  logic              r_err;

  logic              w_aligned;
  logic              w_valid;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  assign w_aligned = (iRAM_ADDR[IDX_LSB-1:0] == '0);
  assign w_valid   = (iRAM_RD ^ iRAM_WR) && w_aligned;
  // Reset gating keeps a WRITE from landing if reset overlaps the edge.
  assign w_we      = (r_state == S_WRITE) && iRST;
  assign w_re      = (r_state == S_READ);

  ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (AW)
  ) u_array (
    .i_clk   (iCLK),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= S_IDLE;
      r_armed <= 1'b1;
      r_idx   <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!iRAM_CE) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            // Any sampled request, good or bad, consumes the arm.
            r_armed <= 1'b0;
            if (w_valid) begin
              r_idx   <= iRAM_ADDR[IDX_LSB +: AW];
              r_wdata <= iRAM_DATA;
              r_state <= iRAM_RD ? S_READ : S_WRITE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_READ:  r_state <= S_RESP;
        S_RESP: begin
          r_data  <= w_rdata;
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_WRITE: begin
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oRAM_DATA = r_data;
  assign oRAM_BUSY = (r_state != S_IDLE);
  assign oRAM_ACK  = r_ack;
  assign oRAM_ERR  = r_err;
endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: hand-computed vectors for read/write
// latency, arm behaviour, rejects, mid-write reset and capture of inputs.
module tb_data_ram_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, rd, wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] dout;
  logic        busy, ack, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_ram_responder dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iRAM_CE   (ce),
    .iRAM_RD   (rd),
    .iRAM_WR   (wr),
    .iRAM_ADDR (addr),
    .iRAM_DATA (wdata),
    .oRAM_DATA (dout),
    .oRAM_BUSY (busy),
    .oRAM_ACK  (ack),
    .oRAM_ERR  (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CE pulse, then CE low for the rest of a 6-cycle observation window.
  // With scr set, ADDR/DATA are scrambled right after the request edge.
  task automatic req(input logic r, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input bit scr,
                     output int ack_n, output int err_n, output int busy_n,
                     output int ack_at, output int err_at, output logic [31:0] rdat);
    ack_n = 0; err_n = 0; busy_n = 0; ack_at = -1; err_at = -1; rdat = '0;
    ce = 1'b1; rd = r; wr = w; addr = a; wdata = d;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (busy) busy_n++;
      if (ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = k;
        rdat = dout;
      end
      if (err) begin
        err_n++;
        if (err_at < 0) err_at = k;
      end
      if (k == 1) begin
        ce = 1'b0;
        if (scr) begin
          addr  = a ^ 8'h24;
          wdata = ~d;
        end
      end
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  int an, en, bn, aat, eat, cnt;
  logic [31:0] q;

  initial begin
    rst_n = 1'b0; ce = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    chk("rst_data", dout, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ack",  {31'b0, ack},  32'h0);
    chk("rst_err",  {31'b0, err},  32'h0);
    rst_n = 1'b1;
    tick();

    // Write then read word 0
    req(1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0, an, en, bn, aat, eat, q);
    chk("wr0_ack_n", an, 1);
    chk("wr0_ack_at", aat, 2);
    chk("wr0_busy_n", bn, 1);
    req(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("rd0_ack_n", an, 1);
    chk("rd0_ack_at", aat, 3);
    chk("rd0_busy_n", bn, 2);
    chk("rd0_data", q, 32'hDEADBEEF);
    chk("rd0_hold", dout, 32'hDEADBEEF);

    // Top word, bottom unaffected
    req(1'b0, 1'b1, 8'hFC, 32'h12345678, 1'b0, an, en, bn, aat, eat, q);
    req(1'b1, 1'b0, 8'hFC, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("rdFC_data", q, 32'h12345678);
    req(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("rd00_after_FC", q, 32'hDEADBEEF);

    // CE held high: one ACK only, then re-arm after one low cycle
    ce = 1'b1; rd = 1'b1; addr = 8'hFC; cnt = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (ack) cnt++; end
    chk("hold_one_ack", cnt, 1);
    ce = 1'b0; tick();
    ce = 1'b1; cnt = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (ack) cnt++; end
    chk("rearm_ack", cnt, 1);
    chk("rearm_data", dout, 32'h12345678);
    ce = 1'b0; rd = 1'b0; tick();

    // Rejects: misaligned and RD==WR
    req(1'b0, 1'b1, 8'h04, 32'h00C0FFEE, 1'b0, an, en, bn, aat, eat, q);
    req(1'b0, 1'b1, 8'h05, 32'h11111111, 1'b0, an, en, bn, aat, eat, q);
    chk("mis_err_n", en, 1);
    chk("mis_err_at", eat, 1);
    chk("mis_ack_n", an, 0);
    chk("mis_busy_n", bn, 0);
    req(1'b1, 1'b1, 8'h04, 32'h22222222, 1'b0, an, en, bn, aat, eat, q);
    chk("rdwr_err_n", en, 1);
    chk("rdwr_ack_n", an, 0);
    chk("rdwr_busy_n", bn, 0);
    req(1'b0, 1'b0, 8'h04, 32'h33333333, 1'b0, an, en, bn, aat, eat, q);
    chk("none_err_n", en, 1);
    req(1'b1, 1'b0, 8'h04, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("rej_mem_kept", q, 32'h00C0FFEE);

    // Reset during WRITE drops the write
    req(1'b0, 1'b1, 8'h10, 32'h00000001, 1'b0, an, en, bn, aat, eat, q);
    ce = 1'b1; wr = 1'b1; addr = 8'h10; wdata = 32'hAAAA5555;
    tick();
    chk("wrst_busy_pre", {31'b0, busy}, 32'h1);
    ce = 1'b0; wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wrst_busy", {31'b0, busy}, 32'h0);
    chk("wrst_data", dout, 32'h0);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin tick(); if (ack) cnt++; end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin tick(); if (ack) cnt++; end
    chk("wrst_no_ack", cnt, 0);
    req(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("wrst_mem_old", q, 32'h00000001);

    // Inputs scrambled while busy: captured values must be used
    req(1'b0, 1'b1, 8'h20, 32'h11112222, 1'b1, an, en, bn, aat, eat, q);
    req(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("cap_wr_data", q, 32'h11112222);
    req(1'b1, 1'b0, 8'h04, 32'h0, 1'b0, an, en, bn, aat, eat, q);
    chk("cap_wr_other", q, 32'h00C0FFEE);
    req(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, an, en, bn, aat, eat, q);
    chk("cap_rd_data", q, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
